// File: rtl/hamming_15_11_serial_rx_if.sv
// Serial link bundle between the Hamming(15,11) receiver and its neighbours.
// The master drives the incoming codeword stream. The slave (the receiver)
// drives the corrected data stream and the frame status.
interface hamming_15_11_serial_rx_if;
    logic       shift;
    logic       sl_inn;
    logic       sl_out;
    logic       out_valid;
    logic       frame_done;
    logic       err_corrected;
    logic [3:0] syndrome;

    modport master (
        output shift, sl_inn,
        input  sl_out, out_valid, frame_done, err_corrected, syndrome
    );

    modport slave (
        input  shift, sl_inn,
        output sl_out, out_valid, frame_done, err_corrected, syndrome
    );
endinterface

// File: rtl/hamming_15_11_serial_rx.sv
// Serial Hamming(15,11) SEC receiver.
// The receive shift register fills while the previous frame is still being
// streamed out, so back-to-back frames flow without stalls. The syndrome and
// the corrected data are computed from the full receive register in the
// cycle that rx_full is high.
module hamming_15_11_serial_rx (
    input  logic                          clk,
    input  logic                          RST,
    hamming_15_11_serial_rx_if.slave      bus
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // rx_sr_q[p-1] holds codeword position p once all 15 bits are in.
    logic [14:0] rx_sr_q, rx_sr_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic        rx_full_q, rx_full_d;

    state_t      state_q, state_d;
    logic [9:0]  tx_sr_q, tx_sr_d;     // d2..d11 waiting, next bit at [0]
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic        sl_out_q, sl_out_d;
    logic        out_valid_q, out_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;
    logic [3:0]  syn_q, syn_d;

    logic [3:0]  syn_c;
    logic [14:0] cw_fix;
    logic [10:0] data_c;

    // Receive side: capture one bit per shift cycle, flag a complete frame.
    always_comb begin
        rx_sr_d   = rx_sr_q;
        rx_cnt_d  = rx_cnt_q;
        rx_full_d = 1'b0;
        if (bus.shift) begin
            rx_sr_d = {bus.sl_inn, rx_sr_q[14:1]};
            if (rx_cnt_q == 4'd14) begin
                rx_cnt_d  = 4'd0;
                rx_full_d = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + 4'd1;
            end
        end
    end

    // Syndrome, single-bit correction and data extraction.
    always_comb begin
        syn_c = 4'd0;
        for (int i = 0; i < 15; i++)
            if (rx_sr_q[i]) syn_c = syn_c ^ 4'(i + 1);
        cw_fix = rx_sr_q;
        for (int i = 0; i < 15; i++)
            if (syn_c == 4'(i + 1)) cw_fix[i] = ~rx_sr_q[i];
        // d1 = pos 3, d2..d4 = pos 5..7, d5..d11 = pos 9..15
        data_c = {cw_fix[14:8], cw_fix[6:4], cw_fix[2]};
    end

    // FSM next state: a completed frame always restarts transmission.
    always_comb begin
        state_d = state_q;
        if (rx_full_q)
            state_d = SEND;
        else if (state_q == SEND && tx_cnt_q == 4'd10)
            state_d = IDLE;
    end

    // FSM outputs and transmit datapath.
    always_comb begin
        sl_out_d     = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        tx_sr_d      = tx_sr_q;
        tx_cnt_d     = tx_cnt_q;
        syn_d        = syn_q;
        err_d        = err_q;
        if (rx_full_q) begin
            syn_d        = syn_c;
            err_d        = (syn_c != 4'd0);
            sl_out_d     = data_c[0];
            tx_sr_d      = data_c[10:1];
            tx_cnt_d     = 4'd0;
            out_valid_d  = 1'b1;
            frame_done_d = 1'b1;
        end else if (state_q == SEND && tx_cnt_q != 4'd10) begin
            sl_out_d    = tx_sr_q[0];
            tx_sr_d     = {1'b0, tx_sr_q[9:1]};
            tx_cnt_d    = tx_cnt_q + 4'd1;
            out_valid_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rx_sr_q      <= '0;
            rx_cnt_q     <= '0;
            rx_full_q    <= 1'b0;
            state_q      <= IDLE;
            tx_sr_q      <= '0;
            tx_cnt_q     <= '0;
            sl_out_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            syn_q        <= '0;
        end else begin
            rx_sr_q      <= rx_sr_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_full_q    <= rx_full_d;
            state_q      <= state_d;
            tx_sr_q      <= tx_sr_d;
            tx_cnt_q     <= tx_cnt_d;
            sl_out_q     <= sl_out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            syn_q        <= syn_d;
        end
    end

    assign bus.sl_out        = sl_out_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.err_corrected = err_q;
    assign bus.syndrome      = syn_q;
endmodule

// File: tb/tb_hamming_15_11_serial_rx.sv
// Directed bench for the serial Hamming(15,11) receiver. Expected frames are
// queued as they are driven; a monitor pops and checks them as bursts appear.
module tb_hamming_15_11_serial_rx;
    typedef struct {
        logic [10:0] data;
        logic [3:0]  syn;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic RST;
    hamming_15_11_serial_rx_if bus ();

    hamming_15_11_serial_rx dut (.clk(clk), .RST(RST), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    exp_t        cur;
    logic [10:0] got;
    int          bit_idx  = 0;
    int          low_run  = 1000;
    int          last_gap = -1;
    logic        active   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference encoder: place data, then set each parity for even groups.
    function automatic logic [15:1] enc(input logic [10:0] d);
        logic [15:1] cw;
        int dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        cw = '0;
        for (int j = 0; j < 11; j++) cw[dpos[j]] = d[j];
        for (int k = 0; k < 4; k++) begin
            logic p;
            p = 1'b0;
            for (int i = 1; i <= 15; i++)
                if (((i >> k) & 1) == 1) p = p ^ cw[i];
            cw[1 << k] = p;
        end
        return cw;
    endfunction

    // Monitor: frame status checked at frame_done, data after 11 valid bits.
    always @(negedge clk) begin
        if (!RST) begin
            bit_idx = 0;
            active  = 1'b0;
        end else begin
            if (bus.frame_done) begin
                check("fd_valid", 32'(bus.out_valid), 32'd1);
                last_gap = low_run;
                if (q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    active = 1'b0;
                end else begin
                    cur = q.pop_front();
                    check("syndrome", 32'(bus.syndrome), 32'(cur.syn));
                    check("err_corrected", 32'(bus.err_corrected), 32'(cur.err));
                    active  = 1'b1;
                    bit_idx = 0;
                end
            end
            if (bus.out_valid) begin
                low_run = 0;
                if (active) begin
                    got[bit_idx] = bus.sl_out;
                    bit_idx++;
                    if (bit_idx == 11) begin
                        check("data", 32'(got), 32'(cur.data));
                        active = 1'b0;
                    end
                end
            end else begin
                low_run++;
                if (bus.sl_out !== 1'b0) check("sl_out_idle", 32'(bus.sl_out), 32'd0);
            end
        end
    end

    // Drive one frame with an optional shift gap after bit gap_after.
    task automatic send_frame(input logic [15:1] cw, input int gap_after, input int gap_len,
                              input logic [10:0] d, input logic [3:0] s, input string tag);
        exp_t e;
        e.data = d; e.syn = s; e.err = (s != 4'd0);
        q.push_back(e);
        for (int p = 1; p <= 15; p++) begin
            @(negedge clk);
            bus.shift  = 1'b1;
            bus.sl_inn = cw[p];
            if (p == gap_after && gap_len > 0) begin
                @(negedge clk);
                bus.shift = 1'b0;
                repeat (gap_len - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        bus.shift = 1'b0;
        check({tag, "_fd_early"}, 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        check({tag, "_fd_latency"}, 32'(bus.frame_done), 32'd1);
        repeat (12) @(negedge clk);
    endtask

    logic [15:1] clean, cw;
    logic [10:0] rd;
    int          pos;

    initial begin
        clean      = 15'b000_0000_0000_0111; // positions 1,2,3 set
        RST        = 1'b0;
        bus.shift  = 1'b0;
        bus.sl_inn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sl_out", 32'(bus.sl_out), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_syndrome", 32'(bus.syndrome), 32'd0);
        check("rst_err", 32'(bus.err_corrected), 32'd0);
        RST = 1'b1;

        send_frame(clean, 0, 0, 11'd1, 4'd0, "clean");
        cw = clean; cw[6] = ~cw[6];
        send_frame(cw, 0, 0, 11'd1, 4'd6, "data_err");
        cw = clean; cw[8] = ~cw[8];
        send_frame(cw, 0, 0, 11'd1, 4'd8, "parity_err");
        cw = clean; cw[5] = ~cw[5]; cw[6] = ~cw[6];
        send_frame(cw, 0, 0, 11'b000_0000_0110, 4'd3, "double_err");
        send_frame(clean, 7, 5, 11'd1, 4'd0, "gap");

        for (int t = 0; t < 4; t++) begin
            rd  = 11'($urandom);
            pos = $urandom_range(1, 15);
            cw  = enc(rd);
            cw[pos] = ~cw[pos];
            send_frame(cw, 0, 0, rd, 4'(pos), "rand");
        end
        cw = enc(11'h5A3);
        send_frame(cw, 0, 0, 11'h5A3, 4'd0, "rand_clean");

        // Abandon a frame part-way with reset, then two frames back to back.
        for (int p = 1; p <= 7; p++) begin
            @(negedge clk);
            bus.shift  = 1'b1;
            bus.sl_inn = clean[p];
        end
        @(negedge clk);
        RST = 1'b0;
        bus.shift = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_syndrome", 32'(bus.syndrome), 32'd0);
        @(negedge clk);
        RST = 1'b1;
        begin
            exp_t e;
            e.data = 11'd1; e.syn = 4'd0; e.err = 1'b0;
            q.push_back(e);
            q.push_back(e);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus.shift  = 1'b1;
            bus.sl_inn = clean[(c % 15) + 1];
        end
        @(negedge clk);
        bus.shift = 1'b0;
        for (int c = 0; c < 40 && (q.size() != 0 || active); c++) @(negedge clk);
        check("b2b_drained", 32'(q.size() + int'(active)), 32'd0);
        check("b2b_gap", 32'(last_gap), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
